// File: rtl/rand_req_arbiter.sv
// Two-requester random value arbiter: a 3-bit LFSR draws values 1..3 until one is allowed by the requester's mask.
// Optional macro ARB_RR_EN turns simultaneous-request arbitration into round-robin (default: A always wins).
module rand_req_arbiter #(
  parameter int MAX_TRIES = 7
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_a,
  input  logic [2:0] mask_a,
  input  logic       req_b,
  input  logic [2:0] mask_b,
  output logic       ack_a,
  output logic       ack_b,
  output logic [1:0] value,
  output logic       fallback,
  output logic       busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_DRAW = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0] state_q, state_d;
  logic [2:0] lfsr_q;
  logic [3:0] tries_q, tries_d;
  logic [2:0] mask_q, mask_d;
  logic       gnt_b_q, gnt_b_d;
  logic [1:0] value_q, value_d;
  logic       fb_q, fb_d;

  logic [1:0] draw;
  logic [2:0] draw_oh;
  logic [1:0] lowest;
  logic       pick_b;
  logic [2:0] sel_mask;
  logic       gnt_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) lfsr_q <= 3'b100;
    else     lfsr_q <= {lfsr_q[1:0], lfsr_q[2] ^ lfsr_q[1]};
  end

  // lfsr[1:0]==00 folds onto value 1 so every cycle yields a legal draw
  always_comb begin
    draw    = 2'd1;
    draw_oh = 3'b001;
    case (lfsr_q[1:0])
      2'b10:   begin draw = 2'd2; draw_oh = 3'b010; end
      2'b11:   begin draw = 2'd3; draw_oh = 3'b100; end
      default: begin draw = 2'd1; draw_oh = 3'b001; end
    endcase
  end

  always_comb begin
    lowest = 2'd3;
    if (mask_q[1]) lowest = 2'd2;
    if (mask_q[0]) lowest = 2'd1;
  end

`ifdef ARB_RR_EN
  logic last_b_q, last_b_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) last_b_q <= 1'b1;
    else     last_b_q <= last_b_d;
  end

  always_comb begin
    last_b_d = last_b_q;
    if (state_q == S_DONE) last_b_d = gnt_b_q;
  end

  assign pick_b = req_b & (~req_a | ~last_b_q);
`else
  assign pick_b = req_b & ~req_a;
`endif

  assign sel_mask = pick_b ? mask_b : mask_a;
  assign gnt_req  = gnt_b_q ? req_b : req_a;

  always_comb begin
    state_d = state_q;
    tries_d = tries_q;
    mask_d  = mask_q;
    gnt_b_d = gnt_b_q;
    value_d = value_q;
    fb_d    = fb_q;
    case (state_q)
      S_IDLE: begin
        if (req_a || req_b) begin
          gnt_b_d = pick_b;
          mask_d  = sel_mask;
          tries_d = 4'd0;
          if (sel_mask == 3'b000) begin
            value_d = 2'd0;
            fb_d    = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_DRAW;
          end
        end
      end
      S_DRAW: begin
        // a withdrawn request abandons the draw and leaves value/fallback alone
        if (!gnt_req) begin
          state_d = S_IDLE;
        end else if ((draw_oh & mask_q) != 3'b000) begin
          value_d = draw;
          fb_d    = 1'b0;
          state_d = S_DONE;
        end else begin
          tries_d = tries_q + 4'd1;
          if (tries_q + 4'd1 == 4'(MAX_TRIES)) begin
            value_d = lowest;
            fb_d    = 1'b1;
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      tries_q <= 4'd0;
      mask_q  <= 3'b000;
      gnt_b_q <= 1'b0;
      value_q <= 2'd0;
      fb_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      tries_q <= tries_d;
      mask_q  <= mask_d;
      gnt_b_q <= gnt_b_d;
      value_q <= value_d;
      fb_q    <= fb_d;
    end
  end

  assign ack_a    = (state_q == S_DONE) & ~gnt_b_q;
  assign ack_b    = (state_q == S_DONE) &  gnt_b_q;
  assign value    = value_q;
  assign fallback = fb_q;
  assign busy     = (state_q != S_IDLE);

endmodule

// File: tb/tb_rand_req_arbiter.sv
// Directed bench for rand_req_arbiter: one instance with MAX_TRIES=7, one with MAX_TRIES=1.
// LFSR after reset release: 100,001,010,101,011,111,110 -> draws 1,1,2,1,3,3,2.
module tb_rand_req_arbiter;

  logic       clk, rst;
  logic       req_a, req_b, ack_a, ack_b, fallback, busy;
  logic [2:0] mask_a, mask_b;
  logic [1:0] value;
  logic       req1_a, req1_b, ack1_a, ack1_b, fallback1, busy1;
  logic [2:0] mask1_a, mask1_b;
  logic [1:0] value1;

  int checks = 0;
  int failures = 0;

  rand_req_arbiter #(.MAX_TRIES(7)) u_dut (
    .clk(clk), .rst(rst),
    .req_a(req_a), .mask_a(mask_a), .req_b(req_b), .mask_b(mask_b),
    .ack_a(ack_a), .ack_b(ack_b), .value(value), .fallback(fallback), .busy(busy)
  );

  rand_req_arbiter #(.MAX_TRIES(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .req_a(req1_a), .mask_a(mask1_a), .req_b(req1_b), .mask_b(mask1_b),
    .ack_a(ack1_a), .ack_b(ack1_b), .value(value1), .fallback(fallback1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic reset_start();
    rst = 1'b1;
    req_a = 1'b0; req_b = 1'b0; mask_a = 3'b000; mask_b = 3'b000;
    req1_a = 1'b0; req1_b = 1'b0; mask1_a = 3'b000; mask1_b = 3'b000;
    repeat (2) @(negedge clk);
  endtask

  // n = negedges until the ack is seen; max+1 on timeout
  task automatic wait_ack(input int which, input int max, output int n);
    logic hit;
    hit = 1'b0;
    n = 0;
    while (!hit && n < max) begin
      @(negedge clk);
      n++;
      case (which)
        0:       hit = ack_a;
        1:       hit = ack_b;
        default: hit = ack1_a;
      endcase
    end
    if (!hit) n = max + 1;
  endtask

  initial begin
    int n;
    int cnt;
    int seq [4];
    int exp_seq [4];
    logic [2:0] t_mask [4];
    logic [1:0] t_val  [4];
    logic       t_fb   [4];

    reset_start();
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_value", value, 0);
    chk("rst_fallback", fallback, 0);
    chk("rst_busy", busy, 0);

    // first draw (1) allowed: ack in second cycle after the sampling edge
    rst = 1'b0; req_a = 1'b1; mask_a = 3'b001;
    wait_ack(0, 8, n);
    chk("first_lat", n, 2);
    chk("first_value", value, 1);
    chk("first_fb", fallback, 0);
    chk("first_ack_b", ack_b, 0);
    req_a = 1'b0;
    @(negedge clk);
    chk("post_ack_a", ack_a, 0);
    chk("post_busy", busy, 0);
    chk("post_value_hold", value, 1);

    // request withdrawn during DRAW
    req_a = 1'b1; mask_a = 3'b100;
    @(negedge clk);
    chk("abort_busy_draw", busy, 1);
    req_a = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ack", ack_a, 0);
    chk("abort_value", value, 1);
    chk("abort_fb", fallback, 0);

    // mask 100 needs a 3 (fifth LFSR state); mask change after grant is ignored
    reset_start();
    rst = 1'b0; req_a = 1'b1; mask_a = 3'b100;
    @(negedge clk);
    mask_a = 3'b001;
    wait_ack(0, 8, n);
    chk("m100_lat", n + 1, 5);
    chk("m100_value", value, 3);
    chk("m100_fb", fallback, 0);
    req_a = 1'b0;

    // empty mask on B
    reset_start();
    rst = 1'b0; req_b = 1'b1; mask_b = 3'b000;
    wait_ack(1, 4, n);
    chk("empty_lat_le2", (n <= 2), 1);
    chk("empty_value", value, 0);
    chk("empty_fb", fallback, 1);
    chk("empty_ack_a", ack_a, 0);
    req_b = 1'b0;

    // MAX_TRIES=1: first draw is 1; a rejection falls back to the lowest allowed value
    t_mask[0] = 3'b010; t_val[0] = 2'd2; t_fb[0] = 1'b1;
    t_mask[1] = 3'b100; t_val[1] = 2'd3; t_fb[1] = 1'b1;
    t_mask[2] = 3'b001; t_val[2] = 2'd1; t_fb[2] = 1'b0;
    t_mask[3] = 3'b110; t_val[3] = 2'd2; t_fb[3] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      reset_start();
      rst = 1'b0; req1_a = 1'b1; mask1_a = t_mask[i];
      wait_ack(2, 4, n);
      chk($sformatf("mt1_lat_%0d", i), n, 2);
      chk($sformatf("mt1_value_%0d", i), value1, t_val[i]);
      chk($sformatf("mt1_fb_%0d", i), fallback1, t_fb[i]);
      req1_a = 1'b0;
    end

    // reset in DRAW cancels; LFSR restarts so mask 010 is met on the second draw
    reset_start();
    rst = 1'b0; req_a = 1'b1; mask_a = 3'b100;
    @(negedge clk);
    chk("rstdraw_busy_pre", busy, 1);
    rst = 1'b1;
    #1;
    chk("rstdraw_busy", busy, 0);
    chk("rstdraw_ack", ack_a, 0);
    chk("rstdraw_value", value, 0);
    chk("rstdraw_fb", fallback, 0);
    @(negedge clk);
    rst = 1'b0; mask_a = 3'b010;
    wait_ack(0, 8, n);
    chk("rstdraw_lat", n, 3);
    chk("rstdraw_val2", value, 2);
    chk("rstdraw_fb2", fallback, 0);
    req_a = 1'b0;

    // both requesters held
`ifdef ARB_RR_EN
    exp_seq[0] = 0; exp_seq[1] = 1; exp_seq[2] = 0; exp_seq[3] = 1;
`else
    exp_seq[0] = 0; exp_seq[1] = 0; exp_seq[2] = 0; exp_seq[3] = 0;
`endif
    reset_start();
    rst = 1'b0; req_a = 1'b1; req_b = 1'b1; mask_a = 3'b111; mask_b = 3'b111;
    cnt = 0;
    for (int i = 0; i < 20 && cnt < 4; i++) begin
      @(negedge clk);
      if (ack_a && ack_b) chk("arb_both_ack", 1, 0);
      if (ack_a)      begin seq[cnt] = 0; cnt++; end
      else if (ack_b) begin seq[cnt] = 1; cnt++; end
    end
    chk("arb_count", cnt, 4);
    for (int i = 0; i < cnt; i++) chk($sformatf("arb_order_%0d", i), seq[i], exp_seq[i]);
    req_a = 1'b0; req_b = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
